// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size and FSM types plus read-latency bounds for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, RSVD} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian byte-lane mask, store data replication and load extraction/extension
// DMEM_MISALIGN_CHECK_EN enables misalignment flagging; otherwise misalign is tied 0.
module dmem_lane_align import dmem_pkg::*; (
  input  logic [1:0]  lo,
  input  size_e       size,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [31:0] rsh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    rsh = rword >> {lo, 3'b000};
    b = rsh[7:0];
    h = lo[1] ? rword[31:16] : rword[15:0];
    mask = size == BYTE ? 4'b0001 << lo : size == HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_sh = size == BYTE ? {4{wdata[7:0]}} : size == HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == BYTE ? {{24{~zext & b[7]}}, b} : size == HALF ? {{16{~zext & h[15]}}, h} : rword;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (size == HALF && lo[0]) || (size == WORD && lo != 2'b00) || size == RSVD;
`else
    misalign = 1'b0;
`endif
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with configurable load latency
// Optional misalignment rejection under DMEM_MISALIGN_CHECK_EN.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_zero_ext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
  state_e      state;
  logic [1:0]  cnt;
  logic        live;
  logic        accept;
  logic        err;
  logic [3:0]  mask;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_ext;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic        unused_addr;
  assign idx = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];
  // live keeps the array write path closed while reset is asserted
  assign req_ready = state == IDLE && live;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  dmem_lane_align u_align (
    .lo(req_addr[1:0]),
    .size(size_e'(req_size)),
    .zext(req_zero_ext),
    .wdata(req_wdata),
    .rword(mem[idx]),
    .mask(mask),
    .wdata_sh(wdata_sh),
    .rdata(rdata_ext),
    .misalign(err)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      live <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        state <= (req_we || RD_LATENCY == 1) ? RESP : WAIT;
        cnt <= CNT_INIT;
        rsp_rdata <= (req_we || err) ? 32'd0 : rdata_ext;
        rsp_err <= err;
      end else if (state == WAIT) begin
        state <= cnt == 2'd0 ? RESP : WAIT;
        cnt <= cnt == 2'd0 ? cnt : cnt - 2'd1;
      end else if (rsp_valid && rsp_ready) begin
        state <= IDLE;
        rsp_rdata <= 32'd0;
        rsp_err <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    if (accept && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic req_zero_ext = 1'b0;
  logic rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0] req_size = 2'd0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic er;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_zero_ext(req_zero_ext), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic zext,
                      input int hold, output logic [31:0] rdo, output logic erro);
    int lat;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_size = size;
    req_zero_ext = zext;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, 32'(lat), we ? 32'd1 : 32'(LAT));
    rdo = rsp_rdata;
    erro = rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_d"}, rsp_rdata, rdo);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    xact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, rd, er);
    chk("st_w10_rd", rd, 32'd0);
    chk("st_w10_err", 32'(er), 32'd0);
    xact("ld_w10", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_w10_rd", rd, 32'hDEADBEEF);
    xact("st_w20", 1'b1, 32'h20, 32'd0, 2'd2, 1'b0, 0, rd, er);
    xact("st_b21", 1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0, 0, rd, er);
    xact("ld_bs21", 1'b0, 32'h21, 32'd0, 2'd0, 1'b0, 0, rd, er);
    chk("ld_bs21_rd", rd, 32'hFFFFFF80);
    xact("ld_bz21", 1'b0, 32'h21, 32'd0, 2'd0, 1'b1, 0, rd, er);
    chk("ld_bz21_rd", rd, 32'h00000080);
    xact("ld_w20", 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_w20_rd", rd, 32'h00008000);
    xact("hold", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5, rd, er);
    chk("hold_rd", rd, 32'hDEADBEEF);
    xact("st_wrap", 1'b1, 32'd4096, 32'h12345678, 2'd2, 1'b0, 0, rd, er);
    xact("ld_wrap", 1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_wrap_rd", rd, 32'h12345678);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h10;
    req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rdata", rsp_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("mrst_hold_valid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_rel_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rel_rdy", 32'(req_ready), 32'd1);
    xact("ld_after_rst", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_after_rst_rd", rd, 32'hDEADBEEF);
    xact("st_h3", 1'b1, 32'h3, 32'h0000AAAA, 2'd1, 1'b0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("st_h3_err", 32'(er), 32'd1);
    chk("st_h3_rd", rd, 32'd0);
    xact("ld_w0", 1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_w0_rd", rd, 32'h12345678);
    chk("ld_w0_err", 32'(er), 32'd0);
    xact("ld_h1", 1'b0, 32'h1, 32'd0, 2'd1, 1'b0, 0, rd, er);
    chk("ld_h1_err", 32'(er), 32'd1);
    chk("ld_h1_rd", rd, 32'd0);
    xact("ld_rsvd", 1'b0, 32'h10, 32'd0, 2'd3, 1'b0, 0, rd, er);
    chk("ld_rsvd_err", 32'(er), 32'd1);
    chk("ld_rsvd_rd", rd, 32'd0);
`else
    chk("st_h3_err", 32'(er), 32'd0);
    xact("ld_w0", 1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_w0_rd", rd, 32'hAAAA5678);
    xact("ld_hs2", 1'b0, 32'h2, 32'd0, 2'd1, 1'b0, 0, rd, er);
    chk("ld_hs2_rd", rd, 32'hFFFFAAAA);
    xact("ld_hz1", 1'b0, 32'h1, 32'd0, 2'd1, 1'b1, 0, rd, er);
    chk("ld_hz1_rd", rd, 32'h00005678);
    xact("ld_bs3", 1'b0, 32'h3, 32'd0, 2'd0, 1'b0, 0, rd, er);
    chk("ld_bs3_rd", rd, 32'hFFFFFFAA);
    xact("ld_rsvd", 1'b0, 32'h12, 32'd0, 2'd3, 1'b1, 0, rd, er);
    chk("ld_rsvd_rd", rd, 32'hDEADBEEF);
    chk("ld_rsvd_err", 32'(er), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the data array depth in 32-bit words and SHALL be a power of two.
REQ-002 Parameter RD_LATENCY, default 2, is the cycles from read accept to rsp_valid; legal range 1..4.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  responder can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_zero_ext  in  1  load result zero-extended when 1, sign-extended when 0.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  requester consumes response.
REQ-014 rsp_rdata  out  32  load result; 0 for stores.
REQ-015 rsp_err  out  1  request rejected (see Configuration).

Function
REQ-016 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted on a rising edge with req_valid=1 and req_ready=1; the request fields are captured on that edge.
REQ-018 IDLE to WAIT on a load accept when RD_LATENCY>1, and IDLE to RESP on a load accept when RD_LATENCY=1.
REQ-019 WAIT counts down; rsp_valid SHALL rise exactly RD_LATENCY cycles after the accept edge.
REQ-020 The store array write SHALL occur on the accept edge, and IDLE SHALL go to RESP so that rsp_valid rises 1 cycle later with rsp_rdata=0.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until an edge with rsp_ready=1, which returns the FSM to IDLE and drops rsp_valid.
REQ-022 There is at most one outstanding request; the earliest next accept is the cycle after the response handshake.
REQ-023 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo array size.
REQ-024 Byte lanes are little-endian.
- Byte access selects lane req_addr[1:0].
- Half access selects lanes {req_addr[1],0} and {req_addr[1],1}.
- A store writes only its selected lanes, with data taken from req_wdata low bits.
REQ-025 Load extraction SHALL extend the selected byte or half to 32 bits per req_zero_ext; req_zero_ext is ignored for word loads.
REQ-026 A load of the address written by the immediately preceding store SHALL return the new data.

Reset
REQ-027 Asserting rst SHALL immediately force the following, without waiting for clk:
- state IDLE, wait counter 0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- req_ready=1 after deassertion.
REQ-028 Reset mid-operation SHALL discard any pending request with no response; array contents are not reset and hold their values.
REQ-029 No array write SHALL occur while rst=0.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN defined: a misaligned request returns rsp_err=1 and rsp_rdata=0 with normal latency and no array write.
- Misaligned means half with addr[0]=1, word with addr[1:0]!=00, or size 11.
REQ-031 DMEM_MISALIGN_CHECK_EN undefined: rsp_err is tied 0.
- A word ignores addr[1:0]; a half ignores addr[0].
- size 11 behaves as word.

Structure
REQ-032 Package dmem_pkg SHALL hold the following; the module imports it:
- the size enum (BYTE, HALF, WORD, RSVD);
- the FSM state enum;
- constants RD_LATENCY_MIN=1 and RD_LATENCY_MAX=4.
REQ-033 Combinational sub-module dmem_lane_align SHALL generate the store byte mask, the shifted write data and the extracted/extended load data.

Verification
REQ-034 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, RD_LATENCY cycles after accept.
REQ-035 Store byte 0x80 @0x21 over word 0x00000000:
- load byte @0x21 with zero_ext=0 -> 0xFFFFFF80;
- load byte @0x21 with zero_ext=1 -> 0x00000080;
- load word @0x20 -> 0x00008000.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held constant and req_ready=0 throughout; handshake returns req_ready=1 next cycle.
REQ-037 Store word 0x12345678 @(DEPTH_WORDS*4) -> load @0x0 returns 0x12345678 (wrap).
REQ-038 Assert rst during WAIT of a load -> rsp_valid never rises; after release, req_ready=1 and a new load completes normally.
REQ-039 With DMEM_MISALIGN_CHECK_EN, store half @0x3 -> rsp_err=1 and memory unchanged; without the macro, the same access writes lanes 2-3 and rsp_err=0.
